// File: rtl/accum_arbiter.sv
// Round-robin arbiter that shares one accumulator between N_REQ requesters and
// routes each final sum back to its owner through an in-order ID FIFO.
module accum_arbiter #(
   parameter int N_REQ    = 4,
   parameter int W_DATA   = 8,
   parameter int W_RES    = 32,
   parameter int ID_DEPTH = 4,
   parameter int W_ID     = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*W_DATA-1:0] req_data,
   input  logic [N_REQ*2-1:0]    req_eot,
   output logic                  acc_valid,
   input  logic                  acc_ready,
   output logic [W_DATA-1:0]     acc_data,
   output logic [1:0]            acc_eot,
   input  logic                  res_valid,
   output logic                  res_ready,
   input  logic [W_RES-1:0]      res_data,
   input  logic [1:0]            res_eot,
   output logic [N_REQ-1:0]      rsp_valid,
   input  logic [N_REQ-1:0]      rsp_ready,
   output logic [W_RES-1:0]      rsp_data,
   output logic [1:0]            rsp_eot,
   output logic                  err
);

   localparam int W_AD  = $clog2(ID_DEPTH);
   localparam int W_PTR = W_AD + 1;

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t           state_q, state_d;
   logic [W_ID-1:0]  grant_q, grant_d;
   logic [W_ID-1:0]  last_grant_q, last_grant_d;
   logic [W_ID-1:0]  id_mem_q [ID_DEPTH];
   logic [W_ID-1:0]  id_mem_d [ID_DEPTH];
   logic [W_PTR-1:0] wr_ptr_q, wr_ptr_d;
   logic [W_PTR-1:0] rd_ptr_q, rd_ptr_d;
   logic             err_q, err_d;

   logic             fifo_full, fifo_empty;
   logic             advance, acc_hs, pop;
   logic [W_ID-1:0]  rr_pick, head_id;

   // Requester index `off` positions after `base`, wrapping at N_REQ.
   function automatic logic [W_ID-1:0] rr_index(input logic [W_ID-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= N_REQ) sum = sum - N_REQ;
      return W_ID'(sum);
   endfunction

   // Scan downwards so the nearest valid requester after last_grant wins.
   always_comb begin
      rr_pick = last_grant_q;
      for (int off = N_REQ; off >= 1; off--) begin
         if (req_valid[rr_index(last_grant_q, off)]) rr_pick = rr_index(last_grant_q, off);
      end
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[W_AD] != rd_ptr_q[W_AD]) &&
                       (wr_ptr_q[W_AD-1:0] == rd_ptr_q[W_AD-1:0]);
   assign head_id    = id_mem_q[rd_ptr_q[W_AD-1:0]];
   assign advance    = (state_q == S_IDLE) && (|req_valid) && !fifo_full;
   assign acc_hs     = acc_valid && acc_ready;
   assign err        = err_q;

   // NOTE: sequential state uses non-blocking assignments only; rst is synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= W_ID'(N_REQ - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         S_IDLE: begin
            if (advance) begin
               state_d = S_LOCKED;
               grant_d = rr_pick;
            end
         end
         S_LOCKED: begin
            if (acc_hs && acc_eot[0]) begin
               state_d      = S_IDLE;
               last_grant_d = grant_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      acc_valid = 1'b0;
      acc_data  = '0;
      acc_eot   = '0;
      req_ready = '0;
      if (state_q == S_LOCKED) begin
         acc_valid          = req_valid[grant_q];
         acc_data           = W_DATA'(req_data >> (int'(grant_q) * W_DATA));
         acc_eot            = 2'(req_eot >> (int'(grant_q) * 2));
         req_ready[grant_q] = acc_ready;
      end
   end

   // Intermediate sums and orphan finals are always accepted and discarded.
   always_comb begin
      rsp_valid = '0;
      res_ready = 1'b1;
      rsp_data  = res_data;
      rsp_eot   = res_eot;
      pop       = 1'b0;
      err_d     = err_q;
      if (res_eot[0]) begin
         if (!fifo_empty) begin
            rsp_valid[head_id] = res_valid;
            res_ready          = rsp_ready[head_id];
            pop                = res_valid && rsp_ready[head_id];
         end else if (res_valid) begin
            err_d = 1'b1;
         end
      end
   end

   always_comb begin
      id_mem_d = id_mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (advance) begin
         id_mem_d[wr_ptr_q[W_AD-1:0]] = rr_pick;
         wr_ptr_d = wr_ptr_q + W_PTR'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + W_PTR'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         err_q    <= err_d;
      end
   end

   // NOTE: storage is not reset; entries are only read between a push and its pop.
   always_ff @(posedge clk) begin
      id_mem_q <= id_mem_d;
   end

endmodule

// File: tb/tb_accum_arbiter.sv
// Randomized bench for accum_arbiter: emulates requesters and the accumulator,
// and compares every cycle against a queue-based model of the arbitration rules.
module tb_accum_arbiter;

   localparam int N     = 4;
   localparam int WD    = 8;
   localparam int WR    = 32;
   localparam int DEPTH = 4;

   typedef struct packed { logic [WD-1:0] data; logic [1:0] eot; } beat_t;
   typedef struct packed { logic [WR-1:0] data; logic [1:0] eot; } res_t;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req_valid, req_ready;
   logic [N*WD-1:0]   req_data;
   logic [N*2-1:0]    req_eot;
   logic              acc_valid, acc_ready;
   logic [WD-1:0]     acc_data;
   logic [1:0]        acc_eot;
   logic              res_valid, res_ready;
   logic [WR-1:0]     res_data;
   logic [1:0]        res_eot;
   logic [N-1:0]      rsp_valid, rsp_ready;
   logic [WR-1:0]     rsp_data;
   logic [1:0]        rsp_eot;
   logic              err;

   accum_arbiter #(.N_REQ(N), .W_DATA(WD), .W_RES(WR), .ID_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_eot(req_eot),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data), .acc_eot(acc_eot),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_eot(res_eot),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_eot(rsp_eot),
      .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // requester sources and end-to-end scoreboard
   beat_t         src_q [N][$];
   beat_t         cur_beat [N];
   bit            cur_valid [N];
   logic [WR-1:0] part_sum [N];
   int            part_beats [N];
   logic [WR-1:0] exp_final_q [N][$];
   // accumulator emulation
   res_t          res_q [$];
   logic [WR-1:0] acc_sum;
   // arbitration model
   int            own_q [$];
   bit            m_locked;
   int            m_grant, m_last;
   bit            m_err;
   // knobs and observations
   int            rand_pct, acc_pct, rsp_pct, res_pct;
   bit            rst_now;
   int            order_q [$];
   int            txn_starts, n_final, cyc, first_req_cyc, first_acc_cyc;
   int            rsp_cnt [N];
   logic [WR-1:0] last_rsp_data;
   logic [1:0]    last_rsp_eot;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic bit roll(input int pct);
      return int'($urandom_range(99)) < pct;
   endfunction

   task automatic clear_model();
      own_q.delete();
      res_q.delete();
      m_locked = 1'b0;
      m_grant  = 0;
      m_last   = N - 1;
      m_err    = 1'b0;
      acc_sum  = '0;
      for (int i = 0; i < N; i++) begin
         src_q[i].delete();
         exp_final_q[i].delete();
         cur_valid[i]  = 1'b0;
         cur_beat[i]   = '0;
         part_sum[i]   = '0;
         part_beats[i] = 0;
      end
   endtask

   task automatic step();
      logic [N-1:0] e_req_ready, e_rsp_valid;
      logic         e_acc_valid, e_res_ready, hs;
      beat_t        b;
      int           pre, g;
      @(negedge clk);
      cyc++;
      rst = rst_now;
      for (int i = 0; i < N; i++) begin
         if (!cur_valid[i]) begin
            if (src_q[i].size() > 0) begin
               cur_beat[i]  = src_q[i].pop_front();
               cur_valid[i] = 1'b1;
            end else if (roll(rand_pct)) begin
               cur_beat[i].data = WD'($urandom);
               cur_beat[i].eot  = {roll(30), roll(35)};
               cur_valid[i]     = 1'b1;
            end
         end
         req_valid[i]         = cur_valid[i];
         req_data[i*WD +: WD] = cur_beat[i].data;
         req_eot[i*2 +: 2]    = cur_beat[i].eot;
         rsp_ready[i]         = roll(rsp_pct);
      end
      acc_ready = roll(acc_pct);
      if (res_q.size() > 0 && roll(res_pct)) begin
         res_valid = 1'b1;
         res_data  = res_q[0].data;
         res_eot   = res_q[0].eot;
      end else begin
         res_valid = 1'b0;
         res_data  = WR'($urandom);
         res_eot   = 2'($urandom);
      end
      #1;
      if (|req_valid && first_req_cyc < 0) first_req_cyc = cyc;
      if (acc_valid && first_acc_cyc < 0) first_acc_cyc = cyc;

      // expected combinational outputs from the model state
      e_acc_valid = m_locked && req_valid[m_grant];
      e_req_ready = '0;
      if (m_locked) e_req_ready[m_grant] = acc_ready;
      e_rsp_valid = '0;
      e_res_ready = 1'b1;
      if (res_eot[0] && own_q.size() > 0) begin
         e_rsp_valid[own_q[0]] = res_valid;
         e_res_ready           = rsp_ready[own_q[0]];
      end
      check("acc_valid", 64'(acc_valid), 64'(e_acc_valid));
      check("req_ready", 64'(req_ready), 64'(e_req_ready));
      if (e_acc_valid) begin
         check("acc_data", 64'(acc_data), 64'(cur_beat[m_grant].data));
         check("acc_eot", 64'(acc_eot), 64'(cur_beat[m_grant].eot));
      end
      check("rsp_valid", 64'(rsp_valid), 64'(e_rsp_valid));
      check("res_ready", 64'(res_ready), 64'(e_res_ready));
      if (|e_rsp_valid) begin
         check("rsp_data", 64'(rsp_data), 64'(res_data));
         check("rsp_eot", 64'(rsp_eot), 64'(res_eot));
      end
      check("err", 64'(err), 64'(m_err));

      // advance the model to the next clock edge
      if (rst_now) begin
         clear_model();
      end else begin
         hs  = e_acc_valid && acc_ready;
         pre = own_q.size();
         for (int i = 0; i < N; i++) begin
            if (e_rsp_valid[i] && rsp_ready[i]) begin
               rsp_cnt[i]++;
               n_final++;
               last_rsp_data = rsp_data;
               last_rsp_eot  = rsp_eot;
               if (exp_final_q[i].size() > 0)
                  check("final_sum", 64'(rsp_data), 64'(exp_final_q[i].pop_front()));
               else
                  check("final_pending", 64'(exp_final_q[i].size()), 64'(1));
            end
         end
         if (res_valid && e_res_ready) res_q.delete(0);
         if (res_valid && res_eot[0]) begin
            if (pre > 0) begin
               if (rsp_ready[own_q[0]]) own_q.delete(0);
            end else begin
               m_err = 1'b1;
            end
         end
         if (hs) begin
            g = m_grant;
            b = cur_beat[g];
            cur_valid[g] = 1'b0;
            if (part_beats[g] == 0) begin
               order_q.push_back(g);
               txn_starts++;
            end
            part_beats[g]++;
            part_sum[g] += WR'(b.data);
            acc_sum     += WR'(b.data);
            res_q.push_back('{data: acc_sum, eot: b.eot});
            if (b.eot[0]) begin
               exp_final_q[g].push_back(part_sum[g]);
               part_sum[g]   = '0;
               part_beats[g] = 0;
               acc_sum       = '0;
               m_last        = m_grant;
               m_locked      = 1'b0;
            end
         end else if (!m_locked && |req_valid && pre < DEPTH) begin
            for (int k = N; k >= 1; k--) begin
               if (req_valid[(m_last + k) % N]) g = (m_last + k) % N;
            end
            own_q.push_back(g);
            m_locked = 1'b1;
            m_grant  = g;
         end
      end
   endtask

   task automatic do_reset();
      rst_now = 1'b1;
      step();
      rst_now = 1'b0;
      txn_starts = 0;
      order_q.delete();
      for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
   endtask

   initial begin
      int exp_order [3] = '{0, 1, 0};
      int pending;
      rst = 1'b1;
      req_valid = '0; req_data = '0; req_eot = '0;
      acc_ready = 1'b0; res_valid = 1'b0; res_data = '0; res_eot = '0; rsp_ready = '0;
      clear_model();
      cyc = 0; n_final = 0; first_req_cyc = -1; first_acc_cyc = -1;
      rand_pct = 0; acc_pct = 100; rsp_pct = 100; res_pct = 100; rst_now = 1'b0;
      do_reset();
      do_reset();

      // reset state
      step();
      check("rst_acc_valid", 64'(acc_valid), 64'(0));
      check("rst_req_ready", 64'(req_ready), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_res_ready", 64'(res_ready), 64'(1));
      check("rst_err", 64'(err), 64'(0));

      // single requester: only the final sum 21 reaches requester 2
      src_q[2].push_back('{data: 8'd5, eot: 2'b00});
      src_q[2].push_back('{data: 8'd7, eot: 2'b00});
      src_q[2].push_back('{data: 8'd9, eot: 2'b01});
      first_req_cyc = -1;
      first_acc_cyc = -1;
      repeat (12) step();
      check("t1_grant_latency", 64'(first_acc_cyc - first_req_cyc), 64'(1));
      check("t1_rsp_count", 64'(rsp_cnt[2]), 64'(1));
      check("t1_rsp_other", 64'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[3]), 64'(0));
      check("t1_rsp_data", 64'(last_rsp_data), 64'(21));
      check("t1_rsp_eot", 64'(last_rsp_eot), 64'(2'b01));

      // round-robin between requesters 0 and 1
      do_reset();
      src_q[0].push_back('{data: 8'd1, eot: 2'b00});
      src_q[0].push_back('{data: 8'd2, eot: 2'b01});
      src_q[0].push_back('{data: 8'd3, eot: 2'b00});
      src_q[0].push_back('{data: 8'd4, eot: 2'b01});
      src_q[1].push_back('{data: 8'd5, eot: 2'b00});
      src_q[1].push_back('{data: 8'd6, eot: 2'b01});
      repeat (20) step();
      check("t2_txn_count", 64'(order_q.size()), 64'(3));
      for (int k = 0; k < 3; k++)
         check("t2_order", 64'(k < order_q.size() ? order_q[k] : -1), 64'(exp_order[k]));

      // ID FIFO full: four grants, then the fifth waits for one pop
      do_reset();
      rsp_pct = 0;
      src_q[0].push_back('{data: 8'd1, eot: 2'b01});
      src_q[0].push_back('{data: 8'd2, eot: 2'b01});
      src_q[1].push_back('{data: 8'd3, eot: 2'b01});
      src_q[2].push_back('{data: 8'd4, eot: 2'b01});
      src_q[3].push_back('{data: 8'd5, eot: 2'b01});
      repeat (20) step();
      check("t3_grants_full", 64'(txn_starts), 64'(4));
      rsp_pct = 100;
      step();
      rsp_pct = 0;
      repeat (10) step();
      check("t3_grant_after_pop", 64'(txn_starts), 64'(5));
      rsp_pct = 100;
      repeat (15) step();
      check("t3_rsp_total", 64'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 64'(5));

      // reset in the middle of a four-beat transaction
      do_reset();
      src_q[1].push_back('{data: 8'd10, eot: 2'b00});
      src_q[1].push_back('{data: 8'd11, eot: 2'b00});
      src_q[1].push_back('{data: 8'd12, eot: 2'b00});
      src_q[1].push_back('{data: 8'd13, eot: 2'b01});
      for (int k = 0; k < 20 && part_beats[1] < 2; k++) step();
      check("t5_beats_before_rst", 64'(part_beats[1]), 64'(2));
      do_reset();
      step();
      check("t5_acc_valid", 64'(acc_valid), 64'(0));
      check("t5_err", 64'(err), 64'(0));
      src_q[3].push_back('{data: 8'd20, eot: 2'b01});
      src_q[0].push_back('{data: 8'd21, eot: 2'b01});
      order_q.delete();
      repeat (8) step();
      check("t5_first_grant", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'(0));

      // orphan final result with an empty ID FIFO
      do_reset();
      res_q.push_back('{data: 32'h55, eot: 2'b01});
      step();
      check("t6_res_ready", 64'(res_ready), 64'(1));
      check("t6_rsp_valid", 64'(rsp_valid), 64'(0));
      step();
      check("t6_err_set", 64'(err), 64'(1));
      repeat (3) step();
      check("t6_err_sticky", 64'(err), 64'(1));
      do_reset();
      step();
      check("t6_err_cleared", 64'(err), 64'(0));

      // randomized traffic with backpressure and occasional resets
      n_final  = 0;
      rand_pct = 40;
      for (int p = 0; p < 4; p++) begin
         acc_pct = (p % 2 == 0) ? 100 : 50;
         rsp_pct = (p < 2) ? 100 : 30;
         res_pct = (p == 3) ? 50 : 90;
         repeat (400) begin
            rst_now = ($urandom_range(299) == 0);
            step();
         end
         rst_now = 1'b0;
      end
      rand_pct = 0; acc_pct = 100; rsp_pct = 100; res_pct = 100;
      repeat (60) step();
      pending = 0;
      for (int i = 0; i < N; i++) pending += exp_final_q[i].size();
      check("rand_all_delivered", 64'(pending), 64'(0));
      check("rand_progress", 64'(n_final > 50), 64'(1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule
